// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO arbiter: FSM state encoding,
// grant identifiers and default bus widths.
package mmio_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 32;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_RD   = 4'b0100,
    S_WR   = 4'b1000
  } state_e;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time
// gets the grant; a sole requester always wins.
module rr_arb2 import mmio_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt
);
  always_comb begin
    gnt = GNT_M0;
    if (req == 2'b11)  gnt = ~last_gnt;
    else if (req[1])   gnt = GNT_M1;
  end
endmodule

// File: rtl/mmio_arbiter.sv
// Shares one mmio slave port between IFU (m0, read-only) and LSU (m1, read/write).
// One transaction in flight, round-robin grant, sticky watchdog for slave hangs.
module mmio_arbiter import mmio_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_arAddr,
  input  logic [LEN_W-1:0]  m0_arWidth,
  input  logic              m0_arValid,
  output logic              m0_arReady,
  output logic [DATA_W-1:0] m0_rData,
  output logic              m0_rValid,
  input  logic              m0_rReady,
  input  logic [ADDR_W-1:0] m1_arAddr,
  input  logic [LEN_W-1:0]  m1_arWidth,
  input  logic              m1_arValid,
  output logic              m1_arReady,
  output logic [DATA_W-1:0] m1_rData,
  output logic              m1_rValid,
  input  logic              m1_rReady,
  input  logic [ADDR_W-1:0] m1_wAddr,
  input  logic [DATA_W-1:0] m1_wData,
  input  logic [LEN_W-1:0]  m1_wWidth,
  input  logic              m1_wValid,
  output logic              m1_wReady,
  output logic [ADDR_W-1:0] s_arAddr,
  output logic [LEN_W-1:0]  s_arWidth,
  output logic              s_arValid,
  input  logic              s_arReady,
  input  logic [DATA_W-1:0] s_rData,
  input  logic              s_rValid,
  output logic              s_rReady,
  output logic [ADDR_W-1:0] s_wAddr,
  output logic [DATA_W-1:0] s_wData,
  output logic [LEN_W-1:0]  s_wWidth,
  output logic              s_wValid,
  input  logic              s_wReady,
  output logic              hang,
  output logic [ADDR_W-1:0] hang_addr
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state, state_nxt;
  logic              gnt_q, gnt_nxt, last_gnt, last_nxt, arb_gnt;
  logic [1:0]        req;
  logic              rd_hs;
  logic [ADDR_W-1:0] rd_addr_q, wd_addr;
  logic [WD_W-1:0]   wd_cnt;

  assign req = {m1_wValid | m1_arValid, m0_arValid};

  rr_arb2 u_arb (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt)
  );

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt_q;
    last_nxt   = last_gnt;
    m0_arReady = 1'b0;
    m1_arReady = 1'b0;
    m0_rValid  = 1'b0;
    m1_rValid  = 1'b0;
    m0_rData   = '0;
    m1_rData   = '0;
    m1_wReady  = 1'b0;
    s_arValid  = 1'b0;
    s_arAddr   = '0;
    s_arWidth  = '0;
    s_rReady   = 1'b0;
    s_wValid   = 1'b0;
    s_wAddr    = '0;
    s_wData    = '0;
    s_wWidth   = '0;
    rd_hs      = 1'b0;
    wd_addr    = '0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          gnt_nxt   = arb_gnt;
          // a granted LSU with a pending write issues the write before its read
          state_nxt = (arb_gnt == GNT_M1 && m1_wValid) ? S_WR : S_AR;
        end
      end
      S_AR: begin
        s_arValid = 1'b1;
        s_arAddr  = (gnt_q == GNT_M1) ? m1_arAddr  : m0_arAddr;
        s_arWidth = (gnt_q == GNT_M1) ? m1_arWidth : m0_arWidth;
        if (gnt_q == GNT_M1) m1_arReady = s_arReady;
        else                 m0_arReady = s_arReady;
        wd_addr = s_arAddr;
        if (s_arReady) state_nxt = S_RD;
      end
      S_RD: begin
        if (gnt_q == GNT_M1) begin
          m1_rValid = s_rValid;
          m1_rData  = s_rData;
          s_rReady  = m1_rReady;
        end else begin
          m0_rValid = s_rValid;
          m0_rData  = s_rData;
          s_rReady  = m0_rReady;
        end
        rd_hs   = s_rValid & ((gnt_q == GNT_M1) ? m1_rReady : m0_rReady);
        wd_addr = rd_addr_q;
        if (rd_hs) begin
          state_nxt = S_IDLE;
          last_nxt  = gnt_q;
        end
      end
      S_WR: begin
        s_wValid  = 1'b1;
        s_wAddr   = m1_wAddr;
        s_wData   = m1_wData;
        s_wWidth  = m1_wWidth;
        m1_wReady = s_wReady;
        wd_addr   = m1_wAddr;
        if (s_wReady) begin
          state_nxt = S_IDLE;
          last_nxt  = GNT_M1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      gnt_q     <= GNT_M0;
      last_gnt  <= GNT_M1;
      rd_addr_q <= '0;
      wd_cnt    <= '0;
      hang      <= 1'b0;
      hang_addr <= '0;
    end else begin
      state    <= state_nxt;
      gnt_q    <= gnt_nxt;
      last_gnt <= last_nxt;
      // master may change arAddr after the AR handshake; keep it for hang reporting
      if (state == S_AR && s_arReady) rd_addr_q <= s_arAddr;
      if (state_nxt != state)                          wd_cnt <= '0;
      else if (state != S_IDLE && wd_cnt != WD_LAST)   wd_cnt <= wd_cnt + 1'b1;
      if (TIMEOUT != 0 && state != S_IDLE && wd_cnt == WD_LAST && !hang) begin
        hang      <= 1'b1;
        hang_addr <= wd_addr;
      end
    end
  end
endmodule
